// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Constants and state encodings shared by the UART receive and
//                transmit paths. Parity-mode codes and the RX state encoding
//                live here so both directions agree on them.
//  Contents    : PBIT_NONE / PBIT_EVEN / PBIT_ODD parity-mode codes,
//                rx_state_t receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Parity-mode codes on the pbit port; code 3 behaves as "none".
    localparam logic [1:0] PBIT_NONE = 2'd0;
    localparam logic [1:0] PBIT_EVEN = 2'd1;
    localparam logic [1:0] PBIT_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/parity_calculator.sv
`default_nettype none
// ============================================================================
//  Module      : parity_calculator
//  Description : Computes the parity bit for a character of 7 or 8 data bits.
//                Shared by the transmitter and the receiver so that both ends
//                use identical dbit/pbit interpretation.
//  Ports       : data   [DBIT-1:0] in  - character, right-aligned
//                dbit   [3:0]      in  - 7 selects 7 bits, anything else DBIT
//                pbit   [1:0]      in  - parity mode (none/even/odd/none)
//                parity            out - parity bit to transmit / expect
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_calculator
    import uart_rx_pkg::*;
#(
    parameter int DBIT = 8
) (
    input  logic [DBIT-1:0] data,
    input  logic [3:0]      dbit,
    input  logic [1:0]      pbit,
    output logic            parity
);

    int   w_nbits;
    logic w_xor;

    always_comb begin
        w_nbits = (dbit == 4'd7) ? 7 : DBIT;
        w_xor   = 1'b0;
        for (int i = 0; i < DBIT; i++) begin
            if (i < w_nbits) begin
                w_xor = w_xor ^ data[i];
            end
        end
    end

    // Even parity makes the total count of ones even, odd makes it odd.
    always_comb begin
        parity = 1'b0;
        if (pbit == PBIT_EVEN) begin
            parity = w_xor;
        end else if (pbit == PBIT_ODD) begin
            parity = ~w_xor;
        end
    end

endmodule : parity_calculator
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Deserialises an asynchronous line into 7- or
//                8-bit characters with runtime parity (none/even/odd), driven
//                by a 16x oversampling tick. Each bit is sampled mid-cell.
//  Ports       : clk          in  - single clock, rising edge
//                reset_n      in  - asynchronous active-low reset
//                rx           in  - serial line, idle high, asynchronous
//                s_tick       in  - one-clk pulse at 16x baud
//                dbit   [3:0] in  - data bits per frame (7, otherwise 8)
//                pbit   [1:0] in  - parity mode (0 none,1 even,2 odd,3 none)
//                dout   [DBIT-1:0] out - last character, right-aligned
//                rx_done_tick out - one-clk pulse when a frame completes
//                parity_err   out - parity mismatch on last frame
//                frame_err    out - stop bit sampled low on last frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [3:0]      dbit,
    input  logic [1:0]      pbit,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    // Tick counter must reach 15 in data cells and SB_TICK-1 in the stop cell.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0] c_S_MID  = SW'(7);
    localparam logic [SW-1:0] c_S_BIT  = SW'(15);
    localparam logic [SW-1:0] c_S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    c_N_LAST8 = 3'(DBIT - 1);

    // ------------------------------------------------------------------
    // Input synchroniser; both flops reset to the idle (high) level.
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    rx_state_t       r_state;
    logic [SW-1:0]   r_s;
    logic [2:0]      r_n;
    logic [DBIT-1:0] r_b;
    logic            r_cfg_dbit7;   // frame configuration captured at start bit
    logic [1:0]      r_cfg_pbit;
    logic            r_p_rx;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_parity_err;
    logic            r_frame_err;

    logic [DBIT-1:0] w_dout_next;
    logic [2:0]      w_n_last;
    logic            w_par_active;
    logic            w_exp_parity;

    // A 7-bit frame shifts in one bit fewer, so the character sits one
    // position high in the shift register.
    assign w_dout_next  = r_cfg_dbit7 ? (r_b >> 1) : r_b;
    assign w_n_last     = r_cfg_dbit7 ? 3'd6 : c_N_LAST8;
    assign w_par_active = (r_cfg_pbit == PBIT_EVEN) || (r_cfg_pbit == PBIT_ODD);

    parity_calculator #(
        .DBIT (DBIT)
    ) u_parity (
        .data   (w_dout_next),
        .dbit   (r_cfg_dbit7 ? 4'd7 : 4'(DBIT)),
        .pbit   (r_cfg_pbit),
        .parity (w_exp_parity)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            r_cfg_dbit7  <= 1'b0;
            r_cfg_pbit   <= PBIT_NONE;
            r_p_rx       <= 1'b0;
            r_dout       <= '0;
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_s     <= '0;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (s_tick) begin
                        if (r_s == c_S_MID) begin
                            if (!r_rx_s) begin
                                r_s         <= '0;
                                r_n         <= '0;
                                r_cfg_dbit7 <= (dbit == 4'd7);
                                r_cfg_pbit  <= pbit;
                                r_state     <= ST_DATA;
                            end else begin
                                // Glitch shorter than half a bit: ignore it.
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (s_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_s <= '0;
                            r_b <= {r_rx_s, r_b[DBIT-1:1]};
                            if (r_n == w_n_last) begin
                                r_state <= w_par_active ? ST_PARITY : ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (s_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_p_rx  <= r_rx_s;
                            r_s     <= '0;
                            r_state <= ST_STOP;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (s_tick) begin
                        if (r_s == c_S_STOP) begin
                            r_done       <= 1'b1;
                            r_dout       <= w_dout_next;
                            r_frame_err  <= ~r_rx_s;
                            r_parity_err <= w_par_active && (r_p_rx != w_exp_parity);
                            r_state      <= ST_IDLE;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign parity_err   = r_parity_err;
    assign frame_err    = r_frame_err;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A driver serialises frames
//                and queues the expected character, flags and latency; a
//                monitor pops and compares on every rx_done_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic       s_tick;
    logic [3:0] dbit;
    logic [1:0] pbit;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .s_tick       (s_tick),
        .dbit         (dbit),
        .pbit         (pbit),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;
    int   tick_cnt = 0;
    int   start_tick = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // s_tick: one clk high in every four.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            tick_cnt++;
            #1 s_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got pending=%0d required 0", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe, input int lat);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.lat = lat;
        sb.push_back(e);
        n_pushed++;
    endtask

    // par < 0 means no parity bit on the line.
    task automatic send_frame(input logic [7:0] data, input int nb, input int par, input bit stop_ok);
        wait_ticks(1);
        rx = 1'b0;
        start_tick = tick_cnt;
        wait_ticks(16);
        for (int i = 0; i < nb; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
        if (par >= 0) begin
            rx = par[0];
            wait_ticks(16);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_ticks(16);
        end else begin
            // Low across the stop sample point, then back to idle.
            rx = 1'b0;
            wait_ticks(8);
            rx = 1'b1;
            wait_ticks(8);
        end
        rx = 1'b1;
    endtask

    // Monitor / scoreboard
    logic prev_done = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done_tick && prev_done) begin
                chk("done_width", 2, 1);
            end
            if (rx_done_tick) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("dout", int'(dout), int'(e.d));
                    chk("parity_err", int'(parity_err), int'(e.pe));
                    chk("frame_err", int'(frame_err), int'(e.fe));
                    chk("latency_ticks", tick_cnt - start_tick, e.lat);
                end
            end
            prev_done = rx_done_tick;
        end
    end

    initial begin
        reset_n = 1'b0;
        rx      = 1'b1;
        dbit    = 4'd8;
        pbit    = 2'd0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", int'(dout), 0);
        chk("reset_done", int'(rx_done_tick), 0);
        chk("reset_perr", int'(parity_err), 0);
        chk("reset_ferr", int'(frame_err), 0);

        // 8N1 basic
        expect_frame(8'h55, 1'b0, 1'b0, 152);
        send_frame(8'h55, 8, -1, 1'b1);
        wait_ticks(20);

        // 8E1: 0xA3 has four ones, correct even parity bit is 0
        pbit = 2'd1;
        expect_frame(8'hA3, 1'b0, 1'b0, 168);
        send_frame(8'hA3, 8, 0, 1'b1);
        wait_ticks(20);
        expect_frame(8'hA3, 1'b1, 1'b0, 168);
        send_frame(8'hA3, 8, 1, 1'b1);
        wait_ticks(20);

        // 7O1: 0x41 has two ones, odd parity bit is 1
        dbit = 4'd7;
        pbit = 2'd2;
        expect_frame(8'h41, 1'b0, 1'b0, 152);
        send_frame(8'h41, 7, 1, 1'b1);
        wait_ticks(20);

        // Framing error, then recovery
        dbit = 4'd8;
        pbit = 2'd0;
        expect_frame(8'hF0, 1'b0, 1'b1, 152);
        send_frame(8'hF0, 8, -1, 1'b0);
        wait_ticks(20);
        expect_frame(8'h0F, 1'b0, 1'b0, 152);
        send_frame(8'h0F, 8, -1, 1'b1);
        wait_ticks(20);

        // False start: low for 4 ticks only
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
        expect_frame(8'h3C, 1'b0, 1'b0, 152);
        send_frame(8'h3C, 8, -1, 1'b1);
        wait_ticks(20);

        // Config changed mid-frame must not affect the frame in flight
        expect_frame(8'h5A, 1'b0, 1'b0, 152);
        fork
            send_frame(8'h5A, 8, -1, 1'b1);
            begin
                wait_ticks(40);
                dbit = 4'd7;
                pbit = 2'd2;
            end
        join
        dbit = 4'd8;
        pbit = 2'd0;
        wait_ticks(20);

        // Reset in the middle of DATA; this frame produces no output
        fork
            send_frame(8'hC3, 8, -1, 1'b1);
            begin
                wait_ticks(60);
                #2 reset_n = 1'b0;
                #1;
                chk("midreset_dout", int'(dout), 0);
                chk("midreset_done", int'(rx_done_tick), 0);
                chk("midreset_perr", int'(parity_err), 0);
                chk("midreset_ferr", int'(frame_err), 0);
            end
        join
        #3 reset_n = 1'b1;
        wait_ticks(20);
        expect_frame(8'h81, 1'b0, 1'b0, 152);
        send_frame(8'h81, 8, -1, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
        wait_ticks(4);
        chk("pending_expected", sb.size(), 0);
        chk("done_count", n_done, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
